mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF-stage instruction fetch port and the MEM-stage data port (lw/sw) of the 5-stage pipeline.
- Arbitrates and sequences each access over a req/ack memory handshake, and returns per-port ready pulses. Hazard logic uses these pulses to stall IF or MEM.
- Data port has priority, with anti-starvation for fetch. A watchdog flags memories that never acknowledge.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants with a fetch pending before fetch is forced to win (1..15)
- TIMEOUT, 16, BUSY cycles without mem_ack before abort (2..255)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  fetched word; valid when if_ready
- if_ready  out  1  one-cycle completion pulse
- d_req  in  1  data request (MemRead|MemWrite); held until d_ready
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid when d_ready
- d_ready  out  1  one-cycle completion pulse
- mem_req  out  1  memory access in progress
- mem_we  out  1  write enable, qualified by mem_req
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  read data; valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory
- err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. starve_cnt=0, wd_cnt=0, err=0. Asserting reset mid-access abandons the access with no ready pulse. mem_req falls immediately.
- States: IDLE, BUSY_I, BUSY_D, RESP. All outputs are registered.
- IDLE arbitration, evaluated each cycle:
  - d_req only -> BUSY_D.
  - if_req only -> BUSY_I.
  - Both, with starve_cnt < STARVE_MAX -> BUSY_D, starve_cnt+1.
  - Both, with starve_cnt == STARVE_MAX -> BUSY_I.
  - Neither -> stay IDLE.
- Any BUSY_I entry clears starve_cnt. A data grant with no fetch pending leaves starve_cnt unchanged.
- On a grant edge, latch the address into mem_addr. For BUSY_D also latch d_wdata into mem_wdata and d_we into mem_we. For BUSY_I, mem_we=0. mem_req=1 throughout BUSY. wd_cnt is cleared on BUSY entry.
- BUSY, mem_ack=1: capture mem_rdata into if_rdata (BUSY_I) or d_rdata (BUSY_D loads only; stores leave d_rdata unchanged). Go to RESP. mem_req=0 from the next cycle.
- BUSY, mem_ack=0: wd_cnt+1. When wd_cnt reaches TIMEOUT-1 in a cycle without ack, go to RESP with the port's rdata forced to 0 and err set to 1.
- Ack and timeout in the same cycle: ack wins, err is not set.
- RESP: assert exactly one cycle of if_ready or d_ready for the owning port. No arbitration in RESP. Next state is IDLE.
- Latency: grant sampled at cycle T, mem_req high T+1..T+k (mem_ack at T+k), ready at T+k+1, next grant decision at T+k+2. Minimum 3 cycles per access.
- Requesters deassert or change req on the edge after ready. A req still high in IDLE is a new request.
- mem_ack seen in IDLE or RESP is ignored. Address and data changes during BUSY are ignored because the values are latched.
- err is cleared only by reset. The block keeps operating after err is set.

Test Plan:
- Reset: drive rst_n=0 mid-BUSY_D -> mem_req, d_ready, if_ready, err all 0 at once. After release, IDLE with no spurious ready.
- Single fetch: if_req, if_addr=0x40, ack 2 cycles after mem_req with rdata=0x8C220004 -> mem_addr=0x40, mem_we=0, if_ready one cycle at T+3, if_rdata=0x8C220004.
- Simultaneous: if_req=1, d_req=1 load d_addr=0x100, immediate ack -> data serviced first (d_ready at T+2). Fetch granted at T+3 and completes at T+5.
- Starvation, STARVE_MAX=2: if_req held, d_req re-raised after each d_ready -> order is D, D, I, D, D, I.
- Store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF throughout BUSY. d_ready pulses. d_rdata unchanged.
- Timeout, TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then d_ready with d_rdata=0 and err=1 sticky. Ack on that final cycle -> normal completion, err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Data wins by default; fetch is forced through after STARVE_MAX back-to-back data wins.
//
// state  | meaning
// IDLE   | no access in flight, arbitrating each cycle
// BUSY_I | fetch access outstanding, mem_req high
// BUSY_D | load/store access outstanding, mem_req high
// RESP   | one-cycle ready pulse to the owning port
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [3:0]        starve_cnt, starve_nxt;
  logic [7:0]        wd_cnt, wd_nxt;
  logic              mem_req_nxt, mem_we_nxt, if_ready_nxt, d_ready_nxt, err_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, if_rdata_nxt, d_rdata_nxt;
  logic              grant_d, done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wd_cnt     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      wd_cnt     <= wd_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      if_ready   <= if_ready_nxt;
      d_ready    <= d_ready_nxt;
      err        <= err_nxt;
    end
  end

  // Data loses only when fetch is also pending and has been starved long enough.
  assign grant_d = d_req && !(if_req && (starve_cnt == STARVE_LIM));
  // An ack in the watchdog's last cycle still counts as a normal completion.
  assign done    = mem_ack || (wd_cnt == WD_LAST);

  always_comb begin
    state_nxt     = state;
    starve_nxt    = starve_cnt;
    wd_nxt        = wd_cnt;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    if_ready_nxt  = 1'b0;
    d_ready_nxt   = 1'b0;
    err_nxt       = err;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt     = BUSY_D;
          if (if_req) starve_nxt = starve_cnt + 4'd1;
          wd_nxt        = '0;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
        end else if (if_req) begin
          state_nxt    = BUSY_I;
          starve_nxt   = '0;
          wd_nxt       = '0;
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = if_addr;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_nxt   = RESP;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          if (!mem_ack) err_nxt = 1'b1;
          if (state == BUSY_I) begin
            if_rdata_nxt = mem_ack ? mem_rdata : '0;
            if_ready_nxt = 1'b1;
          end else begin
            if (!mem_ack)     d_rdata_nxt = '0;
            else if (!mem_we) d_rdata_nxt = mem_rdata;
            d_ready_nxt = 1'b1;
          end
        end else begin
          wd_nxt = wd_cnt + 8'd1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_MAX=2, TIMEOUT=4): vector table of single
// accesses plus hand sequences for simultaneous requests, starvation and mid-access reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_req, mem_we, err;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;       // mem_req cycle carrying the ack, 0 = never
    logic [31:0] rdata;
    int          exp_lat;   // cycles from request to ready pulse
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ack_lat = 0;
  int          busy_cnt = 0;
  logic [31:0] ack_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; memory model answers on the ack_lat-th cycle of mem_req.
  task automatic tick();
    @(negedge clk);
    if (mem_req) begin
      busy_cnt++;
      mem_ack = (ack_lat != 0) && (busy_cnt == ack_lat);
    end else begin
      busy_cnt = 0;
      mem_ack  = 1'b0;
    end
    mem_rdata = mem_ack ? ack_data : 32'h5A5A5A5A;
  endtask

  task automatic do_access(input vec_t v);
    int   t = 0;
    int   busy = 0;
    logic mem_ok = 1'b1;
    logic wrong = 1'b0;
    logic got = 1'b0;
    ack_lat  = v.lat;
    ack_data = v.rdata;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    while (!got && t < 40) begin
      tick();
      t++;
      if (mem_req) begin
        busy++;
        if (mem_addr !== v.addr || mem_we !== (v.is_d & v.we) ||
            (v.is_d && v.we && mem_wdata !== v.wdata)) mem_ok = 1'b0;
      end
      if (v.is_d ? d_ready : if_ready) got = 1'b1;
      if (v.is_d ? if_ready : d_ready) wrong = 1'b1;
    end
    check({v.name, " latency"}, t, v.exp_lat);
    check({v.name, " mem_req cycles"}, busy, v.exp_lat - 1);
    check({v.name, " latched mem fields"}, {31'd0, mem_ok}, 32'd1);
    check({v.name, " other port ready"}, {31'd0, wrong}, 32'd0);
    check({v.name, " rdata"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    check({v.name, " err"}, {31'd0, err}, {31'd0, v.exp_err});
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    check({v.name, " pulse width"}, {29'd0, if_ready, d_ready, mem_req}, 32'd0);
  endtask

  vec_t        vecs[10];
  int          td, ti, n;
  logic [5:0]  order;
  logic        bad;

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    vecs[0] = '{"fetch 0x40",    1'b0, 1'b0, 32'h40,  32'h0,        2, 32'h8C220004, 3, 32'h8C220004, 1'b0};
    vecs[1] = '{"load 0x100",    1'b1, 1'b0, 32'h100, 32'h0,        1, 32'h11112222, 2, 32'h11112222, 1'b0};
    vecs[2] = '{"store 0x200",   1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 3, 32'hFFFF0000, 4, 32'h11112222, 1'b0};
    vecs[3] = '{"fetch 0x44",    1'b0, 1'b0, 32'h44,  32'h0,        1, 32'h00000013, 2, 32'h00000013, 1'b0};
    vecs[4] = '{"load lat3",     1'b1, 1'b0, 32'h204, 32'h0,        3, 32'hCAFEF00D, 4, 32'hCAFEF00D, 1'b0};
    vecs[5] = '{"load ack last", 1'b1, 1'b0, 32'h208, 32'h0,        4, 32'h0BADC0DE, 5, 32'h0BADC0DE, 1'b0};
    vecs[6] = '{"fetch ack last",1'b0, 1'b0, 32'h48,  32'h0,        4, 32'h12345678, 5, 32'h12345678, 1'b0};
    vecs[7] = '{"load timeout",  1'b1, 1'b0, 32'h300, 32'h0,        0, 32'h0,        5, 32'h0,        1'b1};
    vecs[8] = '{"fetch after err",1'b0,1'b0, 32'h4C,  32'h0,        1, 32'h00A00093, 2, 32'h00A00093, 1'b1};
    vecs[9] = '{"fetch timeout", 1'b0, 1'b0, 32'h50,  32'h0,        0, 32'h0,        5, 32'h0,        1'b1};

    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("reset outputs", {28'd0, mem_req, if_ready, d_ready, err}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle after reset", {29'd0, mem_req, if_ready, d_ready}, 32'd0);

    for (int i = 0; i < 10; i++) do_access(vecs[i]);

    // Both pending: data first, fetch on the following arbitration.
    ack_lat = 1; ack_data = 32'h22220000;
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    td = 0; ti = 0;
    for (int t = 1; t <= 30 && ti == 0; t++) begin
      tick();
      if (d_ready && td == 0) begin
        td = t;
        check("simul d_rdata", d_rdata, 32'h22220000);
        d_req = 1'b0;
        ack_data = 32'h33330000;
      end
      if (if_ready) begin
        ti = t;
        check("simul if_rdata", if_rdata, 32'h33330000);
        if_req = 1'b0;
      end
    end
    check("simul d_ready cycle", td, 2);
    check("simul if_ready cycle", ti, 5);
    tick();

    // Fetch held, data always re-requesting: D D I D D I.
    ack_lat = 1; ack_data = 32'h44440000;
    if_req = 1'b1; if_addr = 32'h90; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180;
    order = '0; n = 0;
    for (int t = 0; t < 60 && n < 6; t++) begin
      tick();
      if (d_ready) begin order = {order[4:0], 1'b1}; n++; end
      else if (if_ready) begin order = {order[4:0], 1'b0}; n++; end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("starve grant count", n, 6);
    check("starve order", {26'd0, order}, 32'b110110);
    tick(); tick();

    // Reset in the middle of a data access, with err still set from the timeouts.
    ack_lat = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h01234567;
    tick(); tick();
    check("pre-reset busy", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {28'd0, mem_req, if_ready, d_ready, err}, 32'd0);
    d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (if_ready || d_ready || mem_req) bad = 1'b1;
    end
    check("no spurious ready after reset", {31'd0, bad}, 32'd0);
    do_access('{"load after reset", 1'b1, 1'b0, 32'h600, 32'h0, 2, 32'h76543210, 3, 32'h76543210, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
